// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register with valid/ready handshake and a 2-entry skid
// buffer. A synchronous flush squashes every buffered entry, and out_ctrl is
// masked whenever the stage is empty so bubbles never raise write enables.
// Optional feature macro: PIPE_STALL_CNT_EN adds a saturating stall_cnt port
// that counts cycles with out_valid=1 and out_ready=0.
module exe_mem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int CTRL_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DEST_W-1:0] in_dest,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_val_rm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DEST_W-1:0] out_dest,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_val_rm
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic accept;
  logic drain;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  // Main entry drives the outputs; skid entry absorbs one result under backpressure.
  logic [CTRL_W-1:0] main_ctrl_p1, skid_ctrl_p1;
  logic [DEST_W-1:0] main_dest_p1, skid_dest_p1;
  logic [DATA_W-1:0] main_alu_p1,  skid_alu_p1;
  logic [DATA_W-1:0] main_rm_p1,   skid_rm_p1;

  // Handshake flags come from the state register only, so out_ready never
  // reaches in_ready combinationally.
  assign out_valid = (state != S_EMPTY);
  assign in_ready  = (state != S_TWO);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_EMPTY;
    else     state <= state_nxt;
  end

  // Next-state and payload-load decode; flush drops any simultaneous input.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      S_EMPTY: begin
        if (accept) begin
          load_main_in = 1'b1;
          state_nxt    = S_ONE;
        end
      end
      S_ONE: begin
        if (accept && drain) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_nxt = S_TWO;
        end else if (drain) begin
          state_nxt = S_EMPTY;
        end
      end
      S_TWO: begin
        if (drain) begin
          load_main_skid = 1'b1;
          state_nxt      = S_ONE;
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
    if (flush) begin
      state_nxt      = S_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // ---- stage p1: main entry ----
  // Main payload: load from EXE or promote the skid entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_ctrl_p1 <= '0;
      main_dest_p1 <= '0;
      main_alu_p1  <= '0;
      main_rm_p1   <= '0;
    end else if (load_main_in) begin
      main_ctrl_p1 <= in_ctrl;
      main_dest_p1 <= in_dest;
      main_alu_p1  <= in_alu;
      main_rm_p1   <= in_val_rm;
    end else if (load_main_skid) begin
      main_ctrl_p1 <= skid_ctrl_p1;
      main_dest_p1 <= skid_dest_p1;
      main_alu_p1  <= skid_alu_p1;
      main_rm_p1   <= skid_rm_p1;
    end
  end

  // ---- stage p1: skid entry ----
  // Skid payload: captures the input when main is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_ctrl_p1 <= '0;
      skid_dest_p1 <= '0;
      skid_alu_p1  <= '0;
      skid_rm_p1   <= '0;
    end else if (load_skid) begin
      skid_ctrl_p1 <= in_ctrl;
      skid_dest_p1 <= in_dest;
      skid_alu_p1  <= in_alu;
      skid_rm_p1   <= in_val_rm;
    end
  end

  // Control is masked on bubbles; data fields show main contents as-is.
  assign out_ctrl   = main_ctrl_p1 & {CTRL_W{out_valid}};
  assign out_dest   = main_dest_p1;
  assign out_alu    = main_alu_p1;
  assign out_val_rm = main_rm_p1;

`ifdef PIPE_STALL_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    return v + 1'b1;
  endfunction

  // Stall counter: saturating count of blocked cycles; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         stall_cnt <= '0;
    else if (out_valid && !out_ready) stall_cnt <= sat_inc(stall_cnt);
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Self-checking bench for exe_mem_pipe_reg: a queue-based model of the
// 2-deep FIFO behaviour checked every cycle, plus literal expectations.
module tb_exe_mem_pipe_reg;

  localparam int DATA_W = 32;
  localparam int DEST_W = 4;
  localparam int CTRL_W = 3;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DEST_W-1:0] in_dest = '0;
  logic [DATA_W-1:0] in_alu = '0;
  logic [DATA_W-1:0] in_val_rm = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DEST_W-1:0] out_dest;
  logic [DATA_W-1:0] out_alu;
  logic [DATA_W-1:0] out_val_rm;
`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0]  stall_cnt;
`endif

  exe_mem_pipe_reg #(
    .DATA_W(DATA_W), .DEST_W(DEST_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_dest(in_dest), .in_alu(in_alu), .in_val_rm(in_val_rm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_dest(out_dest), .out_alu(out_alu), .out_val_rm(out_val_rm)
`ifdef PIPE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Model: an ordered list of at most two entries; the visible data fields
  // are whatever entry was last at the head.
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rm;
  } ent_t;

  ent_t q[$];
  ent_t shown = '0;
  int   m_stall = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      shown   = '0;
      m_stall = 0;
    end else begin
      automatic bit   full = (q.size() >= 2);
      automatic bit   have = (q.size() > 0);
      automatic ent_t e;
      e.ctrl = in_ctrl; e.dest = in_dest; e.alu = in_alu; e.rm = in_val_rm;
      if (have && !out_ready && m_stall < (1 << CNT_W) - 1) m_stall++;
      if (flush) begin
        q.delete();
      end else begin
        if (have && out_ready) void'(q.pop_front());
        if (in_valid && !full) q.push_back(e);
      end
      if (q.size() > 0) shown = q[0];
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      automatic bit v = (q.size() > 0);
      check("cyc_out_valid", 64'(out_valid), 64'(v));
      check("cyc_in_ready",  64'(in_ready),  64'(q.size() < 2));
      check("cyc_out_ctrl",  64'(out_ctrl),  v ? 64'(shown.ctrl) : 64'd0);
      check("cyc_out_dest",  64'(out_dest),  64'(shown.dest));
      check("cyc_out_alu",   64'(out_alu),   64'(shown.alu));
      check("cyc_out_val_rm", 64'(out_val_rm), 64'(shown.rm));
`ifdef PIPE_STALL_CNT_EN
      check("cyc_stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] a);
    in_valid  = v;
    in_ctrl   = c;
    in_alu    = a;
    in_dest   = a[DEST_W-1:0];
    in_val_rm = ~a;
  endtask

  initial begin
    // Reset then idle.
    #1 rst = 1'b1;
    chk_en = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_ctrl",  64'(out_ctrl),  64'd0);
    check("rst_out_alu",   64'(out_alu),   64'd0);
    check("rst_out_val_rm", 64'(out_val_rm), 64'd0);

    // Streaming at full throughput.
    out_ready = 1'b1;
    drive(1, 3'b001, 32'h11); step();
    check("strm_alu_11", 64'(out_alu), 64'h11);
    check("strm_ctrl",   64'(out_ctrl), 64'd1);
    drive(1, 3'b001, 32'h22); step();
    check("strm_alu_22", 64'(out_alu), 64'h22);
    check("strm_ready",  64'(in_ready), 64'd1);
    drive(1, 3'b001, 32'h33); step();
    check("strm_alu_33", 64'(out_alu), 64'h33);
    check("strm_rm_33",  64'(out_val_rm), 64'hFFFF_FFCC);
    drive(0, 3'b001, 32'h0); step();
    check("strm_empty",  64'(out_valid), 64'd0);
    check("strm_masked", 64'(out_ctrl), 64'd0);

    // Backpressure with a third push ignored while full.
    out_ready = 1'b0;
    drive(1, 3'b011, 32'hA); step();
    check("bp_alu_A", 64'(out_alu), 64'hA);
    drive(1, 3'b011, 32'hB); step();
    check("bp_full_ready", 64'(in_ready), 64'd0);
    drive(1, 3'b011, 32'hC); step();
    check("bp_hold_A", 64'(out_alu), 64'hA);
    check("bp_still_full", 64'(in_ready), 64'd0);
    out_ready = 1'b1; step();
    check("bp_alu_B", 64'(out_alu), 64'hB);
    check("bp_ready_back", 64'(in_ready), 64'd1);
    step();
    check("bp_alu_C", 64'(out_alu), 64'hC);
    drive(0, 3'b000, 32'h0); step();
    check("bp_drained", 64'(out_valid), 64'd0);

    // Flush from the full state with a simultaneous input.
    out_ready = 1'b0;
    drive(1, 3'b100, 32'hD1); step();
    drive(1, 3'b100, 32'hD2); step();
    check("fl_full", 64'(in_ready), 64'd0);
    drive(1, 3'b100, 32'hEE);
    flush = 1'b1; out_ready = 1'b1; step();
    flush = 1'b0;
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_ctrl",  64'(out_ctrl),  64'd0);
    check("fl_ready", 64'(in_ready),  64'd1);
    drive(0, 3'b000, 32'h0); step(); step();
    check("fl_no_EE", 64'(out_alu), 64'hD1);

    // Asynchronous reset between edges while full.
    out_ready = 1'b0;
    drive(1, 3'b101, 32'h5A); step();
    drive(1, 3'b101, 32'h6B); step();
    drive(0, 3'b000, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_ready", 64'(in_ready),  64'd1);
    check("arst_ctrl",  64'(out_ctrl),  64'd0);
    check("arst_dest",  64'(out_dest),  64'd0);
    check("arst_alu",   64'(out_alu),   64'd0);
    step();
    rst = 1'b0;
    step();

`ifdef PIPE_STALL_CNT_EN
    // Stall counter saturation, immune to flush, cleared by rst.
    out_ready = 1'b0;
    drive(1, 3'b001, 32'h77); step();
    drive(0, 3'b000, 32'h0);
    repeat (5) step();
    check("stall_sat", 64'(stall_cnt), 64'd3);
    flush = 1'b1; step(); flush = 1'b0;
    check("stall_flush", 64'(stall_cnt), 64'd3);
    #2 rst = 1'b1; #1;
    check("stall_rst", 64'(stall_cnt), 64'd0);
    step(); rst = 1'b0; step();
`endif

    // Mixed traffic checked by the per-cycle model.
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom), $urandom);
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 16) == 0;
      step();
    end
    drive(0, 3'b000, 32'h0);
    flush = 1'b0; out_ready = 1'b1;
    step(); step();
    check("end_empty", 64'(out_valid), 64'd0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
